// File: rtl/var_table_arbiter_pkg.sv
// Shared definitions for the var_table arbiter: access direction codes,
// FSM state encodings, default geometry and the round-robin pick function.
// Optional feature macro: VAR_TABLE_RMW_EN (adds the MODIFY state).
package var_table_arbiter_pkg;

  localparam int DEF_AW = 3;
  localparam int DEF_VN = 8;

  localparam logic VT_READ  = 1'b1;
  localparam logic VT_WRITE = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ACCESS = 3'd1,
    ST_WAIT   = 3'd2,
    ST_DONE   = 3'd3
`ifdef VAR_TABLE_RMW_EN
    ,
    ST_MODIFY = 3'd4
`endif
  } vt_state_e;

  // Two-way round-robin pick: a lone request always wins, on contention the
  // requester that was not served last wins (last=1 means requester 1).
  function automatic logic [1:0] rr_pick(input logic [1:0] req, input logic last);
    logic [1:0] gnt;
    if (req == 2'b11) begin
      gnt = last ? 2'b01 : 2'b10;
    end else begin
      gnt = req;
    end
    return gnt;
  endfunction

endpackage

// File: rtl/var_table_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: combinational grant plus a registered
// last-grant bit that only moves when a grant is actually taken.
module rr_arb2
  import var_table_arbiter_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] gnt
);

  // Reset to "requester 1 served last" so requester 0 wins the first tie.
  logic last_reg;

  // Grant decode from the current requests and the last-grant bit.
  always_comb begin
    gnt = rr_pick(req, last_reg);
  end

  // Remember who was granted so the next tie goes the other way.
  always_ff @(posedge clock) begin
    if (reset) begin
      last_reg <= 1'b1;
    end else if (update && (|gnt)) begin
      last_reg <= gnt[1];
    end
  end

endmodule

// File: rtl/var_table_arbiter.sv
// Shares one var_table port between the BCP unit (requester 0) and the
// decision/backtrack unit (requester 1). One transaction at a time:
// IDLE -> ACCESS -> [WAIT -> [MODIFY]] -> DONE -> IDLE.
// Optional feature macro: VAR_TABLE_RMW_EN (atomic read-OR-write via rmw0/rmw1).
module var_table_arbiter
  import var_table_arbiter_pkg::*;
#(
  parameter int AW        = DEF_AW,
  parameter int VN        = DEF_VN,
  parameter int VT_RD_LAT = 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [VN-1:0] wdata0,
  output logic          ack0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [VN-1:0] wdata1,
  output logic          ack1,
`ifdef VAR_TABLE_RMW_EN
  input  logic          rmw0,
  input  logic          rmw1,
`endif
  output logic [VN-1:0] rdata,
  output logic          busy,
  output logic          vt_en,
  output logic          vt_r_w,
  output logic [AW-1:0] vt_address,
  output logic [VN-1:0] vt_din,
  input  logic [VN-1:0] vt_dout
);

  localparam int CW = (VT_RD_LAT > 1) ? $clog2(VT_RD_LAT) : 1;

  vt_state_e     state_reg, state_next;
  logic          winner_reg;
  logic          we_reg;
  logic          rmw_reg;
  logic [AW-1:0] addr_reg;
  logic [VN-1:0] wdata_reg;
  logic [VN-1:0] rdata_reg;
  logic [CW-1:0] cnt_reg;

  logic [1:0]    req_vec;
  logic [1:0]    arb_gnt;
  logic          arb_update;
  logic          rmw_sel;
  logic [1:0]    ack_vec;

  assign req_vec = {req1, req0};

`ifdef VAR_TABLE_RMW_EN
  assign rmw_sel = arb_gnt[1] ? rmw1 : rmw0;
`else
  assign rmw_sel = 1'b0;
`endif

  rr_arb2 u_arb (
    .clock  (clock),
    .reset  (reset),
    .req    (req_vec),
    .update (arb_update),
    .gnt    (arb_gnt)
  );

  // One-cycle completion pulse goes only to the latched winner.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_ack
      assign ack_vec[gi] = (state_reg == ST_DONE) && (winner_reg == 1'(gi));
    end
  endgenerate

  assign ack0       = ack_vec[0];
  assign ack1       = ack_vec[1];
  assign rdata      = rdata_reg;
  assign busy       = (state_reg != ST_IDLE);
  assign vt_address = addr_reg;

`ifdef VAR_TABLE_RMW_EN
  assign vt_din = (state_reg == ST_MODIFY) ? (rdata_reg | wdata_reg) : wdata_reg;
`else
  assign vt_din = wdata_reg;
`endif

  // State register; reset aborts any transaction in flight without an ack.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state decode and var_table strobes.
  always_comb begin
    state_next = state_reg;
    vt_en      = 1'b0;
    vt_r_w     = 1'b0;
    arb_update = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (|req_vec) begin
          arb_update = 1'b1;
          state_next = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        vt_en  = 1'b1;
        vt_r_w = (rmw_reg || !we_reg) ? VT_READ : VT_WRITE;
        state_next = (we_reg && !rmw_reg) ? ST_DONE : ST_WAIT;
      end
      ST_WAIT: begin
        if (cnt_reg == '0) begin
`ifdef VAR_TABLE_RMW_EN
          state_next = rmw_reg ? ST_MODIFY : ST_DONE;
`else
          state_next = ST_DONE;
`endif
        end
      end
`ifdef VAR_TABLE_RMW_EN
      ST_MODIFY: begin
        vt_en      = 1'b1;
        vt_r_w     = VT_WRITE;
        state_next = ST_DONE;
      end
`endif
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Command latch at grant, read-latency countdown, read-data capture.
  always_ff @(posedge clock) begin
    if (reset) begin
      winner_reg <= 1'b0;
      we_reg     <= 1'b0;
      rmw_reg    <= 1'b0;
      addr_reg   <= '0;
      wdata_reg  <= '0;
      rdata_reg  <= '0;
      cnt_reg    <= '0;
    end else begin
      if ((state_reg == ST_IDLE) && (|arb_gnt)) begin
        winner_reg <= arb_gnt[1];
        we_reg     <= arb_gnt[1] ? we1 : we0;
        rmw_reg    <= rmw_sel;
        addr_reg   <= arb_gnt[1] ? addr1 : addr0;
        wdata_reg  <= arb_gnt[1] ? wdata1 : wdata0;
      end
      if (state_reg == ST_ACCESS) begin
        cnt_reg <= CW'(VT_RD_LAT - 1);
      end
      if (state_reg == ST_WAIT) begin
        if (cnt_reg == '0) begin
          rdata_reg <= vt_dout;
        end else begin
          cnt_reg <= cnt_reg - 1'b1;
        end
      end
    end
  end

endmodule
